// File: rtl/systolic_result_drain_pkg.sv
// Shared types and default sizes for the systolic result drain block.
package systolic_result_drain_pkg;

   localparam int N_DEF      = 4;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      WRITE,
      DONE
   } state_e;

   typedef logic [N_DEF-1:0][DATA_W_DEF-1:0] row_t;

endpackage

// File: rtl/systolic_result_drain_buf.sv
// NxN result register file: one column written per cycle, one row read out.
module systolic_result_buf #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int IW     = 2
) (
   input  logic                       clk,
   input  logic                       col_we,
   input  logic [IW-1:0]              col_idx,
   input  logic [N-1:0][DATA_W-1:0]   col_data,
   input  logic [IW-1:0]              rd_row,
   output logic [N-1:0][DATA_W-1:0]   rd_data
);

   logic [N-1:0][N-1:0][DATA_W-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (col_we) begin
         for (int r = 0; r < N; r++) mem_d[r][col_idx] = col_data[r];
      end
   end

   // Contents are don't-care after reset, so no reset term.
   always_ff @(posedge clk) mem_q <= mem_d;

   assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/systolic_result_drain.sv
// Drains an NxN systolic array column by column, then writes one row per SRAM word.
module systolic_result_drain
   import systolic_result_drain_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [DATA_W-1:0]     shift_out_0,
   input  logic [DATA_W-1:0]     shift_out_1,
   input  logic [DATA_W-1:0]     shift_out_2,
   input  logic [DATA_W-1:0]     shift_out_3,
   output logic                  OutputSign,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [N*DATA_W-1:0]   wr_data,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(N + 1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       row_q, row_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                os_q, os_d;
   logic                wv_q, wv_d;
   logic                done_q, done_d;
   logic                cap_we;
   logic [N-1:0][DATA_W-1:0] lane, rd_row_data;

   // Lane k of the array carries row k of the result.
   for (genvar k = 0; k < N; k++) begin : g_lane
      if (k == 0)      begin : g0 assign lane[k] = shift_out_0; end
      else if (k == 1) begin : g1 assign lane[k] = shift_out_1; end
      else if (k == 2) begin : g2 assign lane[k] = shift_out_2; end
      else if (k == 3) begin : g3 assign lane[k] = shift_out_3; end
      else             begin : gz assign lane[k] = '0; end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      base_d  = base_q;
      cap_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRAIN;
               base_d  = base_addr;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            // Array output lags OutputSign by one cycle, so capture starts at count 1.
            cap_we = (cnt_q != '0);
            if (cnt_q == CW'(N)) begin
               state_d = WRITE;
               row_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WRITE: begin
            if (wv_q && wr_ready) begin
               if (row_q == IW'(N - 1)) begin
                  state_d = DONE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      os_d   = (state_d == DRAIN) && (cnt_d < CW'(N));
      wv_d   = (state_d == WRITE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         os_q    <= 1'b0;
         wv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         base_q  <= base_d;
         os_q    <= os_d;
         wv_q    <= wv_d;
         done_q  <= done_d;
      end
   end

   systolic_result_buf #(
      .N      (N),
      .DATA_W (DATA_W),
      .IW     (IW)
   ) u_buf (
      .clk      (clk),
      .col_we   (cap_we),
      .col_idx  (IW'(cnt_q - 1'b1)),
      .col_data (lane),
      .rd_row   (row_q),
      .rd_data  (rd_row_data)
   );

   assign OutputSign = os_q;
   assign wr_valid   = wv_q;
   assign done       = done_q;
   assign busy       = (state_q != IDLE);
   assign wr_addr    = wv_q ? (base_q + ADDR_W'(row_q)) : '0;
   assign wr_data    = wv_q ? rd_row_data : '0;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: directed drains with hand-computed rows.
module tb_systolic_result_drain;
   import systolic_result_drain_pkg::*;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [7:0]  lane [4];
   logic        OutputSign, wr_valid, busy, done;
   logic        wr_ready = 1'b1;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;

   logic [7:0]  res [4][4];
   logic [31:0] exp_rows [4];
   logic [2:0]  ptr;
   wr_t         exp_q [$];
   int          exp_done_q [$];
   int          total = 0, bad = 0, cyc = 0;
   int          acc_cnt = 0, done_cnt = 0, os_cnt = 0;
   bit          prev_done = 1'b0;

   systolic_result_drain dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .base_addr   (base_addr),
      .shift_out_0 (lane[0]),
      .shift_out_1 (lane[1]),
      .shift_out_2 (lane[2]),
      .shift_out_3 (lane[3]),
      .OutputSign  (OutputSign),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Array model: each OutputSign edge presents the next column one cycle later.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr <= '0;
         for (int k = 0; k < 4; k++) lane[k] <= '0;
      end else if (OutputSign) begin
         for (int k = 0; k < 4; k++) lane[k] <= res[k][ptr[1:0]];
         ptr <= ptr + 3'd1;
      end else if (!busy) begin
         ptr <= '0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares every presented write against the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (OutputSign) os_cnt++;
            if (wr_valid) begin
               if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
               else begin
                  chk("wr_addr", wr_addr, exp_q[0].a);
                  chk("wr_data", wr_data, exp_q[0].d);
                  if (wr_ready) begin
                     void'(exp_q.pop_front());
                     acc_cnt++;
                  end
               end
            end
            if (done) begin
               if (prev_done) chk("done_width", 1, 0);
               if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
               else chk("done_cycle", cyc + 1, exp_done_q.pop_front());
               done_cnt++;
            end
            prev_done = done;
         end else begin
            prev_done = 1'b0;
         end
      end
   end

   task automatic load_row(input int r, input logic [7:0] e0, e1, e2, e3, input logic [31:0] w);
      res[r][0] = e0; res[r][1] = e1; res[r][2] = e2; res[r][3] = e3;
      exp_rows[r] = w;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_OutputSign"}, OutputSign, 0);
      chk({tag, "_wr_valid"}, wr_valid, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic kick(input logic [7:0] b, input int slen);
      for (int r = 0; r < 4; r++) exp_q.push_back('{a: b + 8'(r), d: exp_rows[r]});
      acc_cnt = 0;
      os_cnt  = 0;
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      @(posedge clk); #1;
      start = 1'b0;
      exp_done_q.push_back(cyc + 10 + slen);
      chk("busy_after_start", busy, 1);
   endtask

   task automatic run(input logic [7:0] b, input int srow, input int slen, input bit poke);
      int  st = 0, t = 0, d0;
      bit  poked_w = 1'b0;
      d0 = done_cnt;
      kick(b, slen);
      while (done_cnt == d0 && t < 100) begin
         @(posedge clk); #1;
         t++;
         start = 1'b0;
         wr_ready = 1'b1;
         if (wr_valid && acc_cnt == srow && st < slen) begin
            wr_ready = 1'b0;
            st++;
         end
         if (poke && t == 2) start = 1'b1;
         if (poke && wr_valid && !poked_w) begin
            start = 1'b1;
            poked_w = 1'b1;
         end
      end
      start = 1'b0;
      wr_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("done_count", done_cnt - d0, 1);
      chk("write_count", acc_cnt, 4);
      chk("outputsign_cycles", os_cnt, 4);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #2 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk) rstn = 1'b1;
      repeat (2) @(posedge clk);

      // All elements 30 (0x1E), base 0x10.
      for (int r = 0; r < 4; r++) load_row(r, 8'd30, 8'd30, 8'd30, 8'd30, 32'h1E1E1E1E);
      run(8'h10, -1, 0, 1'b0);

      load_row(0, 8'd96, 8'd104, 8'd112, 8'd120, 32'h78706860);
      load_row(1, 8'd48, 8'd52,  8'd56,  8'd60,  32'h3C383430);
      load_row(2, 8'd48, 8'd52,  8'd56,  8'd60,  32'h3C383430);
      load_row(3, 8'd96, 8'd104, 8'd112, 8'd120, 32'h78706860);
      run(8'h00, -1, 0, 1'b0);

      load_row(0, 8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201);
      load_row(1, 8'h11, 8'h12, 8'h13, 8'h14, 32'h14131211);
      load_row(2, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 32'hD3C2B1A0);
      load_row(3, 8'hFF, 8'h00, 8'h80, 8'h7F, 32'h7F8000FF);
      run(8'h20, 1, 3, 1'b0);

      // Address wrap past 0xFF.
      run(8'hFE, -1, 0, 1'b0);

      // Stray start pulses in DRAIN and WRITE.
      run(8'h40, -1, 0, 1'b1);

      // Reset during row 2 of the write phase.
      begin
         int t = 0;
         kick(8'h80, 0);
         while (!(wr_valid && acc_cnt == 2) && t < 100) begin
            @(posedge clk); #1;
            t++;
         end
         chk("reached_row2", acc_cnt, 2);
         rstn = 1'b0;
         #1;
         chk_zero("midreset");
         exp_q.delete();
         exp_done_q.delete();
         repeat (2) @(posedge clk);
         @(negedge clk) rstn = 1'b1;
         repeat (2) @(posedge clk);
      end
      run(8'h90, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
